// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file: NRD combinational reads, two write ports (port 0 has priority),
// optional write-to-read bypass, optional hard-wired x0, and a per-register pending-write scoreboard.
module regfile_mp_scoreboard #(
   parameter int unsigned DATA     = 32,
   parameter int unsigned ADDR     = 5,
   parameter int unsigned NRD      = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                we0,
   input  logic [ADDR-1:0]     wa0,
   input  logic [DATA-1:0]     wd0,
   input  logic                we1,
   input  logic [ADDR-1:0]     wa1,
   input  logic [DATA-1:0]     wd1,
   input  logic [NRD*ADDR-1:0] ra,
   output logic [NRD*DATA-1:0] rd,
   input  logic                iss_valid,
   input  logic [ADDR-1:0]     iss_rd,
   output logic [NRD-1:0]      busy,
   output logic                stall,
   output logic                wr_collision
);

   localparam int unsigned DEPTH = 2**ADDR;

   logic [DATA-1:0]  regs_q [DEPTH];
   logic [DEPTH-1:0] sb_q, sb_d;
   logic             wr_collision_q, wr_collision_d;
   logic             zr_wa0, zr_wa1, zr_iss;
   logic             acc0, acc1;

   // Port 1 is dropped when it targets the same register as an accepted port-0 write.
   always_comb begin
      zr_wa0         = (ZERO_REG != 0) && (wa0 == '0);
      zr_wa1         = (ZERO_REG != 0) && (wa1 == '0);
      zr_iss         = (ZERO_REG != 0) && (iss_rd == '0);
      acc0           = we0 && !zr_wa0;
      acc1           = we1 && !zr_wa1 && !(acc0 && (wa1 == wa0));
      wr_collision_d = acc0 && we1 && (wa1 == wa0);
      sb_d = sb_q;
      if (acc0) sb_d[wa0] = 1'b0;
      if (acc1) sb_d[wa1] = 1'b0;
      // Set after clear: a freshly issued producer outranks the retiring one.
      if (iss_valid && !zr_iss) sb_d[iss_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         regs_q         <= '{default: '0};
         sb_q           <= '0;
         wr_collision_q <= 1'b0;
      end else begin
         if (acc0) regs_q[wa0] <= wd0;
         if (acc1) regs_q[wa1] <= wd1;
         sb_q           <= sb_d;
         wr_collision_q <= wr_collision_d;
      end
   end

   assign wr_collision = wr_collision_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR-1:0] ra_k;
      logic            hit0, hit1, zr;
      logic [DATA-1:0] rd_k;
      logic            busy_k;

      always_comb begin
         ra_k   = ra[k*ADDR +: ADDR];
         hit0   = (BYPASS != 0) && acc0 && (wa0 == ra_k);
         hit1   = (BYPASS != 0) && acc1 && (wa1 == ra_k);
         zr     = (ZERO_REG != 0) && (ra_k == '0);
         if (zr)        rd_k = '0;
         else if (hit0) rd_k = wd0;
         else if (hit1) rd_k = wd1;
         else           rd_k = regs_q[ra_k];
         busy_k = sb_q[ra_k] && !hit0 && !hit1 && !zr;
      end

      assign rd[k*DATA +: DATA] = rd_k;
      assign busy[k]            = busy_k;
   end

   assign stall = |busy;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed vector bench for regfile_mp_scoreboard; a second BYPASS=0 instance shares all inputs.
module tb_regfile_mp_scoreboard;

   logic        clk = 1'b0;
   logic        rstn;
   logic        we0, we1, iss_valid;
   logic [4:0]  wa0, wa1, iss_rd;
   logic [31:0] wd0, wd1;
   logic [4:0]  ra0, ra1;
   logic [9:0]  ra;
   logic [63:0] rd, rd_nb;
   logic [1:0]  busy, busy_nb;
   logic        stall, stall_nb, coll, coll_nb;

   int checks = 0;
   int errors = 0;

   assign ra = {ra1, ra0};

   always #5 clk = ~clk;

   regfile_mp_scoreboard #(.DATA(32), .ADDR(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut (
      .clk(clk), .rstn(rstn),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy(busy), .stall(stall), .wr_collision(coll)
   );

   regfile_mp_scoreboard #(.DATA(32), .ADDR(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clk(clk), .rstn(rstn),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd_nb),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy(busy_nb), .stall(stall_nb), .wr_collision(coll_nb)
   );

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        iv;
      logic [4:0]  ird;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic [1:0]  e_busy;
      logic        e_stall;
      logic        e_coll;
      logic [31:0] e_nb0;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      we0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0;
      we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
      iss_valid = 1'b0; iss_rd = 5'd0;
   endtask

   initial begin
      // Outputs sampled before the edge that commits each vector's writes.
      //          we0  wa0    wd0            we1  wa1    wd1            ra0    ra1    iv   ird    e_rd0          e_rd1          busy   stall coll  e_nb0
      vecs[0]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd0, 5'd31,1'b0,5'd0, 32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h0};
      vecs[1]  = '{1'b1,5'd5, 32'hDEADBEEF, 1'b0,5'd0, 32'h0,        5'd5, 5'd1, 1'b0,5'd0, 32'hDEADBEEF, 32'h0,        2'b00,1'b0,1'b0,32'h0};
      vecs[2]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd5, 5'd5, 1'b0,5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00,1'b0,1'b0,32'hDEADBEEF};
      vecs[3]  = '{1'b1,5'd7, 32'h11,       1'b1,5'd7, 32'h22,       5'd7, 5'd6, 1'b0,5'd0, 32'h11,       32'h0,        2'b00,1'b0,1'b0,32'h0};
      vecs[4]  = '{1'b0,5'd0, 32'h0,        1'b1,5'd8, 32'h33,       5'd7, 5'd8, 1'b0,5'd0, 32'h11,       32'h33,       2'b00,1'b0,1'b1,32'h11};
      vecs[5]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd8, 5'd7, 1'b0,5'd0, 32'h33,       32'h11,       2'b00,1'b0,1'b0,32'h33};
      vecs[6]  = '{1'b0,5'd0, 32'h0,        1'b1,5'd9, 32'hABCD,     5'd9, 5'd9, 1'b0,5'd0, 32'hABCD,     32'hABCD,     2'b00,1'b0,1'b0,32'h0};
      vecs[7]  = '{1'b1,5'd0, 32'h55,       1'b1,5'd0, 32'h66,       5'd0, 5'd9, 1'b1,5'd0, 32'h0,        32'hABCD,     2'b00,1'b0,1'b0,32'h0};
      vecs[8]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd0, 5'd0, 1'b0,5'd0, 32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h0};
      vecs[9]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd3, 5'd0, 1'b1,5'd3, 32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h0};
      vecs[10] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd3, 5'd3, 1'b0,5'd0, 32'h0,        32'h0,        2'b11,1'b1,1'b0,32'h0};
      vecs[11] = '{1'b0,5'd0, 32'h0,        1'b1,5'd3, 32'h77,       5'd3, 5'd2, 1'b0,5'd0, 32'h77,       32'h0,        2'b00,1'b0,1'b0,32'h0};
      vecs[12] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd3, 5'd3, 1'b0,5'd0, 32'h77,       32'h77,       2'b00,1'b0,1'b0,32'h77};
      vecs[13] = '{1'b1,5'd3, 32'h88,       1'b0,5'd0, 32'h0,        5'd3, 5'd1, 1'b1,5'd3, 32'h88,       32'h0,        2'b00,1'b0,1'b0,32'h77};
      vecs[14] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd3, 5'd3, 1'b0,5'd0, 32'h88,       32'h88,       2'b11,1'b1,1'b0,32'h88};
      vecs[15] = '{1'b1,5'd3, 32'h1,        1'b1,5'd3, 32'h2,        5'd3, 5'd3, 1'b0,5'd0, 32'h1,        32'h1,        2'b00,1'b0,1'b0,32'h88};
      vecs[16] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        5'd3, 5'd3, 1'b0,5'd0, 32'h1,        32'h1,        2'b00,1'b0,1'b1,32'h1};

      idle();
      ra0 = 5'd3; ra1 = 5'd7;
      rstn = 1'b0;
      #3;
      chk("hold_rd0",   rd[31:0],  32'h0);
      chk("hold_busy",  {30'd0, busy}, 32'h0);
      chk("hold_stall", {31'd0, stall}, 32'h0);
      chk("hold_coll",  {31'd0, coll}, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;

      for (int i = 0; i < 32; i++) begin
         ra0 = 5'(i);
         ra1 = 5'(31 - i);
         #1;
         chk("rst_rd0", rd[31:0],  32'h0);
         chk("rst_rd1", rd[63:32], 32'h0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) begin
         we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
         we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
         ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
         iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
         #2;
         chk($sformatf("v%0d_rd0", i),   rd[31:0],        vecs[i].e_rd0);
         chk($sformatf("v%0d_rd1", i),   rd[63:32],       vecs[i].e_rd1);
         chk($sformatf("v%0d_busy", i),  {30'd0, busy},   {30'd0, vecs[i].e_busy});
         chk($sformatf("v%0d_stall", i), {31'd0, stall},  {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d_coll", i),  {31'd0, coll},   {31'd0, vecs[i].e_coll});
         chk($sformatf("v%0d_nb_rd0", i), rd_nb[31:0],    vecs[i].e_nb0);
         @(posedge clk); #1;
      end

      // Mid-operation reset: pending write, scoreboard bit and collision pulse all vanish at once.
      we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h99;
      we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hAA;
      iss_valid = 1'b1; iss_rd = 5'd4;
      ra0 = 5'd4; ra1 = 5'd4;
      @(posedge clk); #1;
      idle();
      #1;
      chk("pre_rst_rd0",  rd[31:0],       32'h99);
      chk("pre_rst_busy", {30'd0, busy},  32'h3);
      chk("pre_rst_coll", {31'd0, coll},  32'h1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_rd0",   rd[31:0],       32'h0);
      chk("mid_rst_busy",  {30'd0, busy},  32'h0);
      chk("mid_rst_stall", {31'd0, stall}, 32'h0);
      chk("mid_rst_coll",  {31'd0, coll},  32'h0);
      chk("mid_rst_nb_rd0", rd_nb[31:0],   32'h0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rd0",  rd[31:0],      32'h0);
      chk("post_rst_busy", {30'd0, busy}, 32'h0);
      chk("post_rst_coll", {31'd0, coll}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Parametrised successor to the single-write register file for the next pipelined RISC-V core.
- Provides NRD combinational read ports and two synchronous write ports: port 0 for ALU writeback, port 1 for the late load/divider return.
- Optional same-cycle write-to-read bypass and optional hard-wired zero register.
- Per-register scoreboard tracking pending writes, which produces a per-read-port busy flag and a decode stall.

Parameters:
DATA, 32, register width in bits
ADDR, 5, address width; depth = 2**ADDR
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a read returns same-cycle write data and sees same-cycle busy clears; 0 = registered values only
ZERO_REG, 1, 1 = register 0 always reads 0 and is never written or marked busy

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
we0  in  1  write enable, port 0 (priority port)
wa0  in  ADDR  write address, port 0
wd0  in  DATA  write data, port 0
we1  in  1  write enable, port 1
wa1  in  ADDR  write address, port 1
wd1  in  DATA  write data, port 1
ra  in  NRD*ADDR  read addresses; port k = ra[k*ADDR +: ADDR]
rd  out  NRD*DATA  read data; port k = rd[k*DATA +: DATA]
iss_valid  in  1  an instruction issues and will write iss_rd later
iss_rd  in  ADDR  destination register of the issuing instruction
busy  out  NRD  busy[k] = the register at ra port k has a pending write
stall  out  1  OR of all busy bits
wr_collision  out  1  registered pulse: both write ports hit the same address last cycle

Behaviour:
- Reset (rstn low, asynchronous):
  - all registers = 0, all scoreboard bits = 0, wr_collision = 0.
  - rd therefore reads 0, busy = 0, stall = 0 while reset is held and after release.
- Writes (rising clk):
  - we0 writes wd0 to wa0; we1 writes wd1 to wa1.
  - Both enabled with wa0 == wa1: port 0 wins, port 1 is dropped, wr_collision = 1 for exactly the next cycle.
  - Both enabled with different addresses: both are written in the same cycle.
  - ZERO_REG=1: writes to address 0 are ignored on both ports and never count as a collision.
- Reads (combinational, zero latency):
  - Each rd port returns reg[ra_k].
  - ZERO_REG=1 and ra_k = 0: returns 0 regardless of any write.
  - BYPASS=1 and a write to ra_k is enabled this cycle: returns the incoming data, with wd0 taking priority over wd1.
  - BYPASS=0: returns the pre-edge contents.
- Scoreboard:
  - sb[2**ADDR] bits.
  - Set: iss_valid at an edge sets sb[iss_rd]. Ignored for address 0 when ZERO_REG=1.
  - Clear: an accepted write on either port clears sb[wa]. A write dropped by a collision does not clear.
  - Set and clear of the same address in the same cycle: set wins, because the new producer is outstanding.
  - Writes to a register whose sb bit is 0 are legal and leave it 0.
- busy / stall:
  - busy[k] = sb[ra_k] AND NOT (BYPASS AND an accepted write to ra_k this cycle).
  - Forced to 0 for address 0 when ZERO_REG=1.
  - stall = |busy, combinational.
- Reset mid-operation discards all register contents and pending scoreboard bits immediately.
- Register array has no reset beyond the rstn clear. Implementation ≈ 150–250 lines with generate loops over NRD.

Test Plan:
- Reset, then read x0..x31 on both ports -> all 0. Write wa0=5, wd0=0xDEADBEEF, then ra=5 next cycle -> 0xDEADBEEF.
- Same cycle: we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 -> reg7 = 0x11, wr_collision = 1 for one cycle. Then we1 only, wa1=8 -> wr_collision = 0.
- BYPASS=1: ra port0 = 9 while we1 writes 9 with 0xABCD in the same cycle -> rd0 = 0xABCD before the edge. With BYPASS=0 -> old value.
- Write 0x55 to x0, iss_valid with iss_rd=0 -> rd = 0, busy = 0 (ZERO_REG=1).
- iss_valid iss_rd=3, next cycle ra=3 -> busy[0] = 1, stall = 1.
  - Cycle with we1 wa1=3: busy = 0 via bypass, and stays 0 after the edge.
  - Same cycle iss_valid iss_rd=3 plus we0 wa0=3: sb3 remains 1 after the edge.
- Set sb for x4, write reg4 = 0x99, assert rstn low mid-cycle -> immediately busy = 0, rd(4) = 0, wr_collision = 0.
